// File: rtl/mem_bus_pkg.sv
// Shared constants and state encoding for the strobe-driven memory bus.
// Width and timing defaults are also used by the memory and CPU sides.
package mem_bus_pkg;

  localparam int DEF_ADDR_W        = 6;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } bus_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mem_bus_tristate.sv
// Bidirectional data pad: drives the shared bus only while oe is high.
// The din tap always reflects the resolved bus value.
module mem_bus_tristate #(
  parameter int DATA_W = 8
) (
  input  logic              oe,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  inout  wire  [DATA_W-1:0] pad
);

  assign pad = oe ? dout : {DATA_W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/mem_bus_master.sv
// Single-outstanding bus initiator: converts valid/ready requests into
// setup / strobe / hold sequences on the shared memory bus.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic [1:0]        state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_* are ignored whenever req_ready is low.

  localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  bus_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              oe;
  logic [DATA_W-1:0] din;

  assign req_ready = (state == ST_IDLE);
  assign busy      = ~req_ready;
  assign state_dbg = state;

  mem_bus_tristate #(.DATA_W(DATA_W)) u_pad (
    .oe   (oe),
    .dout (wdata_q),
    .din  (din),
    .pad  (mem_data)
  );

  // oe is a register cleared by the async reset, so the bus is released
  // in the same cycle a reset arrives, even mid-write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      oe          <= 1'b0;
      mem_address <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            mem_address <= req_addr;
            wdata_q     <= req_wdata;
            write_q     <= req_write;
            oe          <= req_write;
            cnt         <= CNT_W'(SETUP_CYCLES - 1);
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            mem_write <= write_q;
            mem_read  <= ~write_q;
            cnt       <= CNT_W'(STROBE_CYCLES - 1);
            state     <= ST_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            // Memory still drives the bus during this last strobe cycle.
            if (!write_q) rsp_rdata <= din;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            cnt       <= CNT_W'(HOLD_CYCLES - 1);
            state     <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            oe        <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
